// File: rtl/s27_trojan_monitor.sv
// Drives LFSR vectors into an external s27 and checks G17 against a lockstep golden s27; MISR-compacts G17.
// Compare happens at the end of each RUN cycle. There is no backpressure, and START is ignored outside IDLE.
module s27_trojan_monitor #(
  parameter int unsigned NUM_VECTORS  = 256,
  parameter int unsigned CNT_W        = 16,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic             DUT_G17,
  output logic             G0,
  output logic             G1,
  output logic             G2,
  output logic             G3,
  output logic             BUSY,
  output logic             DONE,
  output logic             TROJAN_DET,
  output logic [CNT_W-1:0] FAIL_IDX,
  output logic [15:0]      SIGNATURE
);

  localparam logic [7:0]       SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_nxt;
  logic [CNT_W-1:0] vec_idx;
  logic             flush_cnt;
  logic             g5, g6, g7;
  logic             g8, g9, g10, g11, g12, g13, g14, g15, g16;
  logic             gold_g17;
  logic             mismatch;
  logic [15:0]      misr_nxt;

  // Golden s27 netlist, evaluated on the stimulus currently presented.
  always_comb begin
    g14      = ~G0;
    g8       = g14 & g6;
    g12      = ~(G1 | g7);
    g15      = g12 | g8;
    g16      = G3 | g8;
    g9       = ~(g16 & g15);
    g11      = ~(g5 | g9);
    g10      = ~(g14 | g11);
    g13      = ~(G2 | g12);
    gold_g17 = ~g11;
  end

  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign mismatch = (state == S_RUN) && (DUT_G17 != gold_g17);
  assign misr_nxt = {SIGNATURE[14:0], 1'b0} ^ (SIGNATURE[15] ? 16'h1021 : 16'h0000)
                  ^ {15'b0, DUT_G17};

  // Golden flops clock every cycle on the same driven vector as the external instance.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      g5 <= 1'b0;
      g6 <= 1'b0;
      g7 <= 1'b0;
    end else begin
      g5 <= g10;
      g6 <= g11;
      g7 <= g13;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state            <= S_IDLE;
      {G3, G2, G1, G0} <= 4'b0000;
      BUSY             <= 1'b0;
      DONE             <= 1'b0;
      TROJAN_DET       <= 1'b0;
      FAIL_IDX         <= '0;
      SIGNATURE        <= 16'h0000;
      lfsr             <= SEED_EFF;
      vec_idx          <= '0;
      flush_cnt        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state            <= S_FLUSH;
            BUSY             <= 1'b1;
            TROJAN_DET       <= 1'b0;
            FAIL_IDX         <= '0;
            SIGNATURE        <= 16'h0000;
            lfsr             <= SEED_EFF;
            vec_idx          <= '0;
            flush_cnt        <= 1'b0;
            // Flush vector drives any s27 state to (G5,G6,G7)=(1,0,0).
            {G3, G2, G1, G0} <= 4'b0111;
          end
        end
        S_FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state            <= S_RUN;
            {G3, G2, G1, G0} <= lfsr[3:0];
            lfsr             <= lfsr_nxt;
          end
        end
        S_RUN: begin
          SIGNATURE <= misr_nxt;
          if (mismatch) begin
            TROJAN_DET <= 1'b1;
            if (!TROJAN_DET) FAIL_IDX <= vec_idx;
          end
          if ((vec_idx == LAST_IDX) || (STOP_ON_FAIL && mismatch)) begin
            state            <= S_DONE;
            BUSY             <= 1'b0;
            DONE             <= 1'b1;
            {G3, G2, G1, G0} <= 4'b0000;
          end else begin
            {G3, G2, G1, G0} <= lfsr[3:0];
            lfsr             <= lfsr_nxt;
            vec_idx          <= vec_idx + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
